// File: rtl/writeback_stage_if.sv
// Bus bundle between the MEM stage and the write-back stage: instruction
// fields and candidate sources in, registered MEM/WB results out.
interface writeback_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  localparam int OFF_W = $clog2(WIDTH / 8);

  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] WriteReg;
  logic [1:0]            WBSel;
  logic [1:0]            LoadSize;
  logic                  LoadUnsigned;
  logic [OFF_W-1:0]      ByteOffset;
  logic [WIDTH-1:0]      ALUResult;
  logic [WIDTH-1:0]      MemData;
  logic [WIDTH-1:0]      PCPlus4;
  logic [WIDTH-1:0]      ImmUpper;

  logic                  wb_valid;
  logic                  wb_RegWrite;
  logic [REG_ADDR_W-1:0] wb_WriteReg;
  logic [WIDTH-1:0]      WriteData;
  logic [CNT_W-1:0]      retired_count;

  modport slave (
    input  in_valid, stall, flush, RegWrite, WriteReg, WBSel, LoadSize,
           LoadUnsigned, ByteOffset, ALUResult, MemData, PCPlus4, ImmUpper,
    output wb_valid, wb_RegWrite, wb_WriteReg, WriteData, retired_count
  );

  modport master (
    output in_valid, stall, flush, RegWrite, WriteReg, WBSel, LoadSize,
           LoadUnsigned, ByteOffset, ALUResult, MemData, PCPlus4, ImmUpper,
    input  wb_valid, wb_RegWrite, wb_WriteReg, WriteData, retired_count
  );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage: sub-word load extraction, four-way write-value select
// and a stallable/flushable MEM/WB register with a retired-instruction
// counter. Every output comes straight from a flop.
module writeback_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave bus
);
  localparam int OFF_W = $clog2(WIDTH / 8);

  logic [7:0]            w_lane_byte;
  logic [15:0]           w_lane_half;
  logic [WIDTH-1:0]      w_load_val;
  logic [WIDTH-1:0]      w_next_data;
  logic                  w_wr_en;

  logic                  r_valid;
  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_writereg;
  logic [WIDTH-1:0]      r_writedata;
  logic [CNT_W-1:0]      r_count;

  // Lane picks; a misaligned halfword drops offset bit 0 and rounds down.
  assign w_lane_byte = bus.MemData[{bus.ByteOffset, 3'b000} +: 8];
  assign w_lane_half = bus.MemData[{bus.ByteOffset[OFF_W-1:1], 4'b0000} +: 16];

  // Register 0 is hard-wired, so never request a write to it.
  assign w_wr_en = bus.RegWrite & bus.in_valid &
                   (bus.WriteReg != {REG_ADDR_W{1'b0}});

  // Extend the selected lane to full width; size 11 behaves as a full load.
  always_comb begin
    w_load_val = bus.MemData;
    case (bus.LoadSize)
      2'b10: begin
        if (bus.LoadUnsigned) begin
          w_load_val = {{(WIDTH-8){1'b0}}, w_lane_byte};
        end else begin
          w_load_val = {{(WIDTH-8){w_lane_byte[7]}}, w_lane_byte};
        end
      end
      2'b01: begin
        if (bus.LoadUnsigned) begin
          w_load_val = {{(WIDTH-16){1'b0}}, w_lane_half};
        end else begin
          w_load_val = {{(WIDTH-16){w_lane_half[15]}}, w_lane_half};
        end
      end
      default: w_load_val = bus.MemData;
    endcase
  end

  // Choose the register-file write value; the load path uses the extended value.
  always_comb begin
    w_next_data = bus.ALUResult;
    case (bus.WBSel)
      2'b00:   w_next_data = bus.ALUResult;
      2'b01:   w_next_data = w_load_val;
      2'b10:   w_next_data = bus.PCPlus4;
      2'b11:   w_next_data = bus.ImmUpper;
      default: w_next_data = bus.ALUResult;
    endcase
  end

  // MEM/WB register: reset beats flush, flush beats stall, stall beats capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= {REG_ADDR_W{1'b0}};
      r_writedata <= {WIDTH{1'b0}};
      r_count     <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= {REG_ADDR_W{1'b0}};
      r_writedata <= {WIDTH{1'b0}};
    end else if (bus.stall) begin
      r_valid     <= r_valid;
      r_regwrite  <= r_regwrite;
      r_writereg  <= r_writereg;
      r_writedata <= r_writedata;
    end else if (bus.in_valid) begin
      r_valid     <= 1'b1;
      r_regwrite  <= w_wr_en;
      r_writereg  <= bus.WriteReg;
      r_writedata <= w_next_data;
      r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_valid     <= 1'b0;
      r_regwrite  <= 1'b0;
      r_writereg  <= {REG_ADDR_W{1'b0}};
      r_writedata <= {WIDTH{1'b0}};
    end
  end

  assign bus.wb_valid      = r_valid;
  assign bus.wb_RegWrite   = r_regwrite;
  assign bus.wb_WriteReg   = r_writereg;
  assign bus.WriteData     = r_writedata;
  assign bus.retired_count = r_count;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed cases from the stage's behaviour list
// plus randomized traffic checked against an arithmetic reference model.
module tb_writeback_stage;
  logic clk;
  logic reset;

  int n_vec = 0;
  int n_err = 0;

  writeback_stage_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(32)) bus ();
  writeback_stage_if #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(4))  bus4 ();

  writeback_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  writeback_stage #(.WIDTH(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic        m_valid;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  logic [31:0] m_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // value the register file should receive, from the selection rules
  function automatic logic [31:0] ref_data();
    longint v;
    int     off;
    case (bus.WBSel)
      2'd0: v = longint'(bus.ALUResult);
      2'd2: v = longint'(bus.PCPlus4);
      2'd3: v = longint'(bus.ImmUpper);
      default: begin
        off = int'(bus.ByteOffset);
        if (bus.LoadSize == 2'd2) begin
          v = (longint'(bus.MemData) >> (8 * off)) % 256;
          if (!bus.LoadUnsigned && v >= 128) v = v + 64'sd4294967296 - 256;
        end else if (bus.LoadSize == 2'd1) begin
          off = (off / 2) * 2;
          v = (longint'(bus.MemData) >> (8 * off)) % 65536;
          if (!bus.LoadUnsigned && v >= 32768) v = v + 64'sd4294967296 - 65536;
        end else begin
          v = longint'(bus.MemData);
        end
      end
    endcase
    return v[31:0];
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_valid = 1'b0; m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0; m_cnt = 32'd0;
    end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      m_valid = 1'b0; m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
    end else if (!bus.stall) begin
      m_valid = 1'b1;
      m_rw    = bus.RegWrite && (bus.WriteReg != 5'd0);
      m_wr    = bus.WriteReg;
      m_wd    = ref_data();
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  // apply current inputs on one edge and compare all outputs with the model
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_val("wb_valid",    {63'd0, bus.wb_valid},      {63'd0, m_valid});
    check_val("wb_RegWrite", {63'd0, bus.wb_RegWrite},   {63'd0, m_rw});
    check_val("wb_WriteReg", {59'd0, bus.wb_WriteReg},   {59'd0, m_wr});
    check_val("WriteData",   {32'd0, bus.WriteData},     {32'd0, m_wd});
    check_val("retired",     {32'd0, bus.retired_count}, {32'd0, m_cnt});
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.RegWrite = 1'b1; bus.WriteReg = 5'd8; bus.WBSel = 2'd0;
    bus.LoadSize = 2'd0; bus.LoadUnsigned = 1'b0; bus.ByteOffset = 2'd0;
    bus.ALUResult = 32'hA5A5A5A5; bus.MemData = 32'hDEADBEEF;
    bus.PCPlus4 = 32'h00400010; bus.ImmUpper = 32'h12340000;
  endtask

  logic [31:0] exp_bytes_s [4];
  logic [31:0] exp_bytes_u [4];
  logic [31:0] saved_cnt;

  initial begin
    exp_bytes_s[0] = 32'hFFFFFFEF; exp_bytes_s[1] = 32'hFFFFFFBE;
    exp_bytes_s[2] = 32'hFFFFFFAD; exp_bytes_s[3] = 32'hFFFFFFDE;
    exp_bytes_u[0] = 32'h000000EF; exp_bytes_u[1] = 32'h000000BE;
    exp_bytes_u[2] = 32'h000000AD; exp_bytes_u[3] = 32'h000000DE;

    set_idle();
    bus4.in_valid = 1'b0; bus4.stall = 1'b0; bus4.flush = 1'b0;
    bus4.RegWrite = 1'b1; bus4.WriteReg = 5'd1; bus4.WBSel = 2'd0;
    bus4.LoadSize = 2'd0; bus4.LoadUnsigned = 1'b0; bus4.ByteOffset = 2'd0;
    bus4.ALUResult = 32'h1; bus4.MemData = 32'h2;
    bus4.PCPlus4 = 32'h3; bus4.ImmUpper = 32'h4;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // alternating ALU / load sources
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.WBSel = (i % 2 == 0) ? 2'd0 : 2'd1;
      tick();
      check_val("alt_data", {32'd0, bus.WriteData},
                {32'd0, (i % 2 == 0) ? 32'hA5A5A5A5 : 32'hDEADBEEF});
      check_val("alt_cnt", {32'd0, bus.retired_count}, i + 1);
    end

    // byte loads, signed then unsigned
    bus.WBSel = 2'd1; bus.LoadSize = 2'd2;
    for (int u = 0; u < 2; u++) begin
      bus.LoadUnsigned = u[0];
      for (int o = 0; o < 4; o++) begin
        bus.ByteOffset = o[1:0];
        tick();
        check_val("byte_ld", {32'd0, bus.WriteData},
                  {32'd0, (u == 0) ? exp_bytes_s[o] : exp_bytes_u[o]});
      end
    end

    // halfword loads, aligned and misaligned
    bus.LoadSize = 2'd1; bus.LoadUnsigned = 1'b0;
    bus.ByteOffset = 2'd2; tick();
    check_val("half_al", {32'd0, bus.WriteData}, {32'd0, 32'hFFFFDEAD});
    bus.ByteOffset = 2'd3; tick();
    check_val("half_mis", {32'd0, bus.WriteData}, {32'd0, 32'hFFFFDEAD});

    // PC+4 and upper immediate; write to r0 suppressed but counted
    bus.WBSel = 2'd2; tick();
    check_val("pc4", {32'd0, bus.WriteData}, {32'd0, 32'h00400010});
    bus.WBSel = 2'd3; tick();
    check_val("imm", {32'd0, bus.WriteData}, {32'd0, 32'h12340000});
    saved_cnt = bus.retired_count;
    bus.WriteReg = 5'd0; tick();
    check_val("r0_we", {63'd0, bus.wb_RegWrite}, 64'd0);
    check_val("r0_valid", {63'd0, bus.wb_valid}, 64'd1);
    check_val("r0_cnt", {32'd0, bus.retired_count}, {32'd0, saved_cnt + 32'd1});

    // stall holds for three cycles, release captures the new input
    bus.WriteReg = 5'd8; bus.WBSel = 2'd0; bus.ALUResult = 32'hA5A5A5A5;
    tick();
    saved_cnt = bus.retired_count;
    bus.stall = 1'b1; bus.ALUResult = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("stall_hold", {32'd0, bus.WriteData}, {32'd0, 32'hA5A5A5A5});
      check_val("stall_cnt", {32'd0, bus.retired_count}, {32'd0, saved_cnt});
    end
    bus.stall = 1'b0; tick();
    check_val("stall_rel", {32'd0, bus.WriteData}, {32'd0, 32'hDEADBEEF});
    check_val("stall_rel_cnt", {32'd0, bus.retired_count}, {32'd0, saved_cnt + 32'd1});

    // flush with stall and valid: bubble, count unchanged
    bus.flush = 1'b1; bus.stall = 1'b1; tick();
    check_val("flush_v", {63'd0, bus.wb_valid}, 64'd0);
    check_val("flush_d", {32'd0, bus.WriteData}, 64'd0);
    check_val("flush_cnt", {32'd0, bus.retired_count}, {32'd0, saved_cnt + 32'd1});
    bus.flush = 1'b0; bus.stall = 1'b0; tick();

    // reset during a stall clears everything
    bus.stall = 1'b1; reset = 1'b1; tick();
    check_val("rst_stall_cnt", {32'd0, bus.retired_count}, 64'd0);
    check_val("rst_stall_v", {63'd0, bus.wb_valid}, 64'd0);
    reset = 1'b0; bus.stall = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset             = ($urandom_range(0, 49) == 0);
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.RegWrite      = $urandom_range(0, 1) == 1;
      bus.WriteReg      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.WBSel         = 2'($urandom);
      bus.LoadSize      = 2'($urandom);
      bus.LoadUnsigned  = $urandom_range(0, 1) == 1;
      bus.ByteOffset    = 2'($urandom);
      bus.ALUResult     = $urandom;
      bus.MemData       = $urandom;
      bus.PCPlus4       = $urandom;
      bus.ImmUpper      = $urandom;
      tick();
    end
    reset = 1'b0;
    set_idle();
    tick();

    // narrow counter wraps modulo 16
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("cnt4_start", {60'd0, bus4.retired_count}, 64'd0);
    bus4.in_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      check_val("cnt4_wrap", {60'd0, bus4.retired_count}, i % 16);
    end
    bus4.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised write-back stage for the processor datapath, generalising the two-input MemtoReg select. It picks the register-file write value from four sources, sign- or zero-extends sub-word loads from the selected byte lane, and presents the result through a stallable, flushable MEM/WB pipeline register. A retired-instruction counter for performance checks is also maintained here.

## Interface
- WIDTH, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retired-instruction counter width.
- OFF_W, derived log2(WIDTH/8), byte-offset width; not overridable.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an instruction is present at the stage input.
- stall  input  1  hold the registered outputs this cycle.
- flush  input  1  replace this cycle's capture with a bubble.
- RegWrite  input  1  instruction writes the register file.
- WriteReg  input  REG_ADDR_W  destination register index.
- WBSel  input  2  source select: 00 ALUResult, 01 load data, 10 PCPlus4, 11 ImmUpper.
- LoadSize  input  2  00 full WIDTH, 01 halfword, 10 byte, 11 treated as full.
- LoadUnsigned  input  1  1 zero-extends sub-word loads, 0 sign-extends.
- ByteOffset  input  OFF_W  byte address of the load within the memory word.
- ALUResult, MemData, PCPlus4, ImmUpper  input  WIDTH each  candidate sources.
- wb_valid  output  1  registered instruction valid.
- wb_RegWrite  output  1  registered, qualified write enable.
- wb_WriteReg  output  REG_ADDR_W  registered destination index.
- WriteData  output  WIDTH  registered write value.
- retired_count  output  CNT_W  number of valid instructions captured.

## Operation
- Load extraction is combinational.
  - Byte loads: lane = ByteOffset; bits [8*lane+7 : 8*lane] of MemData.
  - Halfword loads: lane = ByteOffset with bit 0 ignored (misaligned half rounds down); 16 bits from 16*(ByteOffset>>1).
  - Full loads: ByteOffset is ignored.
  - Extension: sub-word values are extended to WIDTH according to LoadUnsigned.
- Source mux: WBSel picks the next write value; 01 selects the extracted load value, not raw MemData.
- Qualified write enable: next wb_RegWrite = RegWrite & in_valid & (WriteReg != 0). Register 0 is never written.
- Register update priority, evaluated every clock: reset > flush > stall > capture.
  - reset: all outputs go to 0, including retired_count.
  - flush: insert a bubble. wb_valid=0, wb_RegWrite=0, wb_WriteReg=0, WriteData=0. Counter unchanged. Flush overrides stall.
  - stall: every output keeps its value. Counter unchanged.
  - capture with in_valid=1: load wb_valid=1, the qualified wb_RegWrite, WriteReg, and the mux result. retired_count increments.
  - capture with in_valid=0: same as a bubble. All other inputs are don't-care.
- Counting rules:
  - Stores and branches (RegWrite=0) still count as retired.
  - retired_count wraps modulo 2^CNT_W with no saturation and no flag.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- There is no combinational path from any input to any output.
- Reset values: wb_valid 0, wb_RegWrite 0, wb_WriteReg 0, WriteData 0, retired_count 0.
- Reset asserted mid-stall or mid-flush clears everything on that edge. The first capture is possible on the edge after reset deasserts.
- stall held for K cycles freezes the outputs for K cycles. The input present on the edge where stall drops is captured.
- Simultaneous flush and stall: bubble, counter unchanged.
- Simultaneous in_valid and flush: the instruction is discarded and not counted.

## Test plan
- Reset, then ALUResult=A5A5A5A5, MemData=DEADBEEF, WBSel alternating 00/01/00/01, in_valid=1, RegWrite=1, WriteReg=8 -> WriteData follows one cycle later as A5A5A5A5, DEADBEEF, A5A5A5A5, DEADBEEF; retired_count reads 1, 2, 3, 4.
- MemData=DEADBEEF, WBSel=01:
  - LoadSize=10, signed, ByteOffset 0..3 -> FFFFFFEF, FFFFFFBE, FFFFFFAD, FFFFFFDE.
  - Same with LoadUnsigned=1 -> 000000EF, 000000BE, 000000AD, 000000DE.
  - LoadSize=01, signed, ByteOffset=2 -> FFFFDEAD.
  - LoadSize=01, signed, ByteOffset=3 -> FFFFDEAD (misaligned, rounds down).
- WBSel=10 with PCPlus4=00400010 -> WriteData 00400010. WBSel=11 with ImmUpper=12340000 -> 12340000. WriteReg=0 with RegWrite=1 -> wb_RegWrite=0, wb_valid=1, counted.
- Capture A5A5A5A5, then stall for 3 cycles while the inputs change to DEADBEEF -> outputs hold A5A5A5A5 and the counter holds. Release stall -> DEADBEEF appears next cycle, counter +1.
- flush together with stall and in_valid -> bubble: all outputs 0, counter unchanged. Reset asserted during a stall -> all outputs 0 on that edge.
- CNT_W=4: 17 valid captures -> retired_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
